xs_rst_seq: RTL and testbench

Reset sequencer for the FPGA top. It takes the board reset, the DDR calibration-done indication and the raw CPU-reset push-button, and produces two registered, ordered active-low resets: `dev_rstn` for the device/uncore domain and `cpu_rstn` for the core. It replaces the loose debounce-plus-flag logic at the top level with one state machine that holds the core until memory is calibrated and the button is released.

---
 rtl/xs_rst_pkg.sv | 21 ++
 rtl/xs_rst_debounce.sv | 45 ++++
 rtl/xs_rst_seq.sv | 122 ++++++++++++
 tb/tb_xs_rst_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xs_rst_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding and
// the delay-counter width rule.
package xs_rst_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_CALIB = 3'd1,
    S_DEV   = 3'd2,
    S_ARM   = 3'd3,
    S_CPU   = 3'd4,
    S_RUN   = 3'd5
  } rst_state_e;

  // Wide enough to hold max(a,b)-1, never narrower than one bit.
  function automatic int dly_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/xs_rst_debounce.sv
// Button synchroniser plus debounce: the output level only toggles after
// DEB_CYCLES consecutive synced cycles that disagree with it.
module xs_rst_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   raw_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign raw_sync = sync[SYNC_STAGES-1];

  // Toggle on the edge the count would reach DEB_CYCLES; saturate, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw_sync == level) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/xs_rst_seq.sv
// Reset sequencer: releases the device domain after DDR calibration, then
// the core once the debounced CPU-reset button is released.
module xs_rst_seq
  import xs_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int DEV_DLY     = 8,
  parameter int CPU_DLY     = 16
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn,
  input  logic       calib_done,
  input  logic       btn_n,
  output logic       dev_rstn,
  output logic       cpu_rstn,
  output logic       btn_db,
  output logic [2:0] seq_state
);

  localparam int DW = dly_width(DEV_DLY, CPU_DLY);
  localparam logic [DW-1:0] DEV_LOAD = DW'(DEV_DLY - 1);
  localparam logic [DW-1:0] CPU_LOAD = DW'(CPU_DLY - 1);

  logic [SYNC_STAGES-1:0] calib_ff;
  logic                   calib_sync;
  rst_state_e             state;
  logic [DW-1:0]          dly;

  always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
    if (!sys_rstn) begin
      calib_ff <= '0;
    end else begin
      calib_ff <= {calib_ff[SYNC_STAGES-2:0], calib_done};
    end
  end

  assign calib_sync = calib_ff[SYNC_STAGES-1];

  xs_rst_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_deb (
    .clk  (sys_clk_i),
    .rst_n(sys_rstn),
    .raw  (btn_n),
    .level(btn_db)
  );

  // Losing calibration outranks everything once past S_CALIB, including a
  // button event seen on the same edge.
  always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state    <= S_RST;
      dly      <= '0;
      dev_rstn <= 1'b0;
      cpu_rstn <= 1'b0;
    end else if ((state inside {S_DEV, S_ARM, S_CPU, S_RUN}) && !calib_sync) begin
      state    <= S_CALIB;
      dly      <= '0;
      dev_rstn <= 1'b0;
      cpu_rstn <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          state    <= S_CALIB;
          dev_rstn <= 1'b0;
          cpu_rstn <= 1'b0;
        end
        S_CALIB: begin
          dev_rstn <= 1'b0;
          cpu_rstn <= 1'b0;
          if (calib_sync) begin
            state <= S_DEV;
            dly   <= DEV_LOAD;
          end
        end
        S_DEV: begin
          if (dly == '0) begin
            state    <= S_ARM;
            dev_rstn <= 1'b1;
          end else begin
            dly <= dly - 1'b1;
          end
        end
        S_ARM: begin
          cpu_rstn <= 1'b0;
          if (btn_db) begin
            state <= S_CPU;
            dly   <= CPU_LOAD;
          end
        end
        S_CPU: begin
          if (!btn_db) begin
            state <= S_ARM;
            dly   <= '0;
          end else if (dly == '0) begin
            state    <= S_RUN;
            cpu_rstn <= 1'b1;
          end else begin
            dly <= dly - 1'b1;
          end
        end
        S_RUN: begin
          if (!btn_db) begin
            state    <= S_ARM;
            cpu_rstn <= 1'b0;
          end
        end
        default: begin
          state    <= S_RST;
          dly      <= '0;
          dev_rstn <= 1'b0;
          cpu_rstn <= 1'b0;
        end
      endcase
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_xs_rst_seq.sv
// Self-checking bench for xs_rst_seq: randomised inputs against an
// event/deadline reference model, plus explicit latency checks.
module tb_xs_rst_seq;

  localparam int S    = 2;
  localparam int DEB  = 16;
  localparam int DDLY = 8;
  localparam int CDLY = 16;
  localparam int P_RST = 0, P_CALIB = 1, P_DEV = 2, P_ARM = 3, P_CPU = 4, P_RUN = 5;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       calib = 1'b0;
  logic       btn   = 1'b1;
  logic       dev_rstn, cpu_rstn, btn_db;
  logic [2:0] seq_state;

  int checks = 0, failures = 0, edge_n = 0;

  bit cq[$], bq[$];
  bit m_db, m_dev, m_cpu;
  int m_ph, m_due, m_run;

  always #5 clk = ~clk;

  xs_rst_seq dut (
    .sys_clk_i (clk),
    .sys_rstn  (rstn),
    .calib_done(calib),
    .btn_n     (btn),
    .dev_rstn  (dev_rstn),
    .cpu_rstn  (cpu_rstn),
    .btn_db    (btn_db),
    .seq_state (seq_state)
  );

  function automatic logic [5:0] obs();
    return {dev_rstn, cpu_rstn, btn_db, seq_state};
  endfunction

  function automatic logic [5:0] expv();
    return {m_dev, m_cpu, m_db, 3'(m_ph)};
  endfunction

  task automatic model_reset();
    cq.delete();
    bq.delete();
    for (int i = 0; i < S; i++) begin
      cq.push_back(1'b0);
      bq.push_back(1'b0);
    end
    m_db = 0; m_dev = 0; m_cpu = 0;
    m_ph = P_RST; m_due = 0; m_run = 0;
  endtask

  // Inputs reach the sequencer S edges after sampling; delays are deadlines.
  task automatic model_step();
    bit c, b, db_old;
    cq.push_back(calib);
    bq.push_back(btn);
    c = cq.pop_front();
    b = bq.pop_front();
    db_old = m_db;
    if (b != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db  = ~m_db;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (!c && m_ph >= P_DEV) begin
      m_ph = P_CALIB; m_dev = 0; m_cpu = 0;
    end else begin
      case (m_ph)
        P_RST:   m_ph = P_CALIB;
        P_CALIB: if (c) begin m_ph = P_DEV; m_due = edge_n + DDLY; end
        P_DEV:   if (edge_n == m_due) begin m_ph = P_ARM; m_dev = 1; end
        P_ARM:   if (db_old) begin m_ph = P_CPU; m_due = edge_n + CDLY; end
        P_CPU:   if (!db_old) m_ph = P_ARM;
                 else if (edge_n == m_due) begin m_ph = P_RUN; m_cpu = 1; end
        P_RUN:   if (!db_old) begin m_ph = P_ARM; m_cpu = 0; end
        default: m_ph = P_RST;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 0; calib = 0; btn = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold got=%b want=%b", obs(), 6'b0);
      end
    end
    rstn = 1;
    tick();
    checks++;
    if (seq_state !== 3'd1) begin
      failures++;
      $display("[TB] FAIL reset_first_edge got=%0d want=1", seq_state);
    end
  endtask

  task automatic test_bringup();
    int t_drive, dev_edge, cpu_edge, arm_edge;
    dev_edge = -1; cpu_edge = -1; arm_edge = -1;
    repeat ($urandom_range(20, 30)) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL bringup_wait edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
    end
    calib = 1;
    t_drive = edge_n;
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL bringup_seq edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
      if (dev_edge < 0 && dev_rstn === 1'b1) dev_edge = edge_n;
      if (arm_edge < 0 && seq_state === 3'd3) arm_edge = edge_n;
      if (cpu_edge < 0 && cpu_rstn === 1'b1) cpu_edge = edge_n;
    end
    checks++;
    if (dev_edge != t_drive + S + DDLY + 1) begin
      failures++;
      $display("[TB] FAIL bringup_dev_latency got=%0d want=%0d", dev_edge, t_drive + S + DDLY + 1);
    end
    checks++;
    if (cpu_edge != arm_edge + CDLY + 1 || arm_edge < 0) begin
      failures++;
      $display("[TB] FAIL bringup_cpu_latency got=%0d want=%0d", cpu_edge, arm_edge + CDLY + 1);
    end
    checks++;
    if (seq_state !== 3'd5) begin
      failures++;
      $display("[TB] FAIL bringup_run_state got=%0d want=5", seq_state);
    end
  endtask

  task automatic test_press();
    int p, r, fall, rise, hold;
    bit dev_low;
    fall = -1; rise = -1; dev_low = 0;
    hold = $urandom_range(30, 50);
    btn = 0;
    p = edge_n + 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL press_hold edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
      if (fall < 0 && cpu_rstn === 1'b0) fall = edge_n;
      if (dev_rstn !== 1'b1) dev_low = 1;
    end
    btn = 1;
    r = edge_n + 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL press_release edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
      if (rise < 0 && cpu_rstn === 1'b1) rise = edge_n;
      if (dev_rstn !== 1'b1) dev_low = 1;
    end
    checks++;
    if (fall != p + S + DEB) begin
      failures++;
      $display("[TB] FAIL press_cpu_fall got=%0d want=%0d", fall, p + S + DEB);
    end
    checks++;
    if (rise != r + S + DEB - 1 + CDLY + 1) begin
      failures++;
      $display("[TB] FAIL press_cpu_rise got=%0d want=%0d", rise, r + S + DEB - 1 + CDLY + 1);
    end
    checks++;
    if (dev_low) begin
      failures++;
      $display("[TB] FAIL press_dev_steady got=dropped want=held_high");
    end
  endtask

  task automatic test_glitch();
    bit disturbed;
    disturbed = 0;
    for (int g = 0; g < 4; g++) begin
      btn = 0;
      repeat ($urandom_range(1, DEB - 1)) begin
        tick();
        checks++;
        if (obs() !== expv()) begin
          failures++;
          $display("[TB] FAIL glitch_low edge=%0d got=%b want=%b", edge_n, obs(), expv());
        end
        if (btn_db !== 1'b1 || cpu_rstn !== 1'b1 || seq_state !== 3'd5) disturbed = 1;
      end
      btn = 1;
      repeat (25) begin
        tick();
        if (btn_db !== 1'b1 || cpu_rstn !== 1'b1 || seq_state !== 3'd5) disturbed = 1;
      end
    end
    checks++;
    if (disturbed) begin
      failures++;
      $display("[TB] FAIL glitch_immunity got=disturbed want=steady_run");
    end
  endtask

  task automatic test_calib_loss();
    int drive, loss_edge, t_drive, dev_edge;
    loss_edge = -1; dev_edge = -1;
    btn = 0;
    repeat (25) tick();
    btn = 1;
    for (int i = 0; i < 60 && m_ph != P_CPU; i++) tick();
    checks++;
    if (seq_state !== 3'(P_CPU) || m_ph != P_CPU) begin
      failures++;
      $display("[TB] FAIL calib_loss_reach_cpu got=%0d want=%0d", seq_state, P_CPU);
    end
    // Loss reaches the sequencer when the delay count reads 5.
    repeat (8) tick();
    calib = 0;
    drive = edge_n;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL calib_loss_seq edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
      if (loss_edge < 0 && seq_state === 3'd1 && dev_rstn === 1'b0 && cpu_rstn === 1'b0)
        loss_edge = edge_n;
    end
    checks++;
    if (loss_edge != drive + 1 + S) begin
      failures++;
      $display("[TB] FAIL calib_loss_edge got=%0d want=%0d", loss_edge, drive + 1 + S);
    end
    repeat ($urandom_range(5, 15)) tick();
    calib = 1;
    t_drive = edge_n;
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL calib_regain_seq edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
      if (dev_edge < 0 && dev_rstn === 1'b1) dev_edge = edge_n;
    end
    checks++;
    if (dev_edge != t_drive + S + DDLY + 1 || seq_state !== 3'd5) begin
      failures++;
      $display("[TB] FAIL calib_regain got=%0d/%0d want=%0d/5", dev_edge, seq_state, t_drive + S + DDLY + 1);
    end
  endtask

  task automatic test_btn_held();
    int b, rise;
    rise = -1;
    rstn = 0; calib = 0; btn = 0;
    model_reset();
    repeat (3) tick();
    rstn = 1;
    repeat (10) tick();
    calib = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL held_wait edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
    end
    checks++;
    if ({dev_rstn, cpu_rstn, seq_state} !== {1'b1, 1'b0, 3'd3}) begin
      failures++;
      $display("[TB] FAIL held_parked got=%b%b/%0d want=10/3", dev_rstn, cpu_rstn, seq_state);
    end
    btn = 1;
    b = edge_n + 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL held_release edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
      if (rise < 0 && cpu_rstn === 1'b1) rise = edge_n;
    end
    checks++;
    if (rise != b + S + DEB - 1 + CDLY + 1) begin
      failures++;
      $display("[TB] FAIL held_cpu_rise got=%0d want=%0d", rise, b + S + DEB - 1 + CDLY + 1);
    end
  endtask

  task automatic test_async_reset();
    calib = 0;
    repeat (5) tick();
    calib = 1;
    for (int i = 0; i < 30 && m_ph != P_DEV; i++) tick();
    repeat (3) tick();
    checks++;
    if (seq_state !== 3'(P_DEV)) begin
      failures++;
      $display("[TB] FAIL async_reach_dev got=%0d want=%0d", seq_state, P_DEV);
    end
    #2;
    rstn = 0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 6'b0) begin
      failures++;
      $display("[TB] FAIL async_immediate got=%b want=%b", obs(), 6'b0);
    end
    @(negedge clk);
    tick();
    rstn = 1;
    tick();
    checks++;
    if (seq_state !== 3'd1) begin
      failures++;
      $display("[TB] FAIL async_restart got=%0d want=1", seq_state);
    end
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("[TB] FAIL async_seq edge=%0d got=%b want=%b", edge_n, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 60; seg++) begin
      calib = ($urandom_range(0, 9) < 8);
      btn   = ($urandom_range(0, 9) < 7);
      repeat ($urandom_range(1, 40)) begin
        tick();
        checks++;
        if (obs() !== expv()) begin
          failures++;
          $display("[TB] FAIL random edge=%0d got=%b want=%b", edge_n, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at edge=%0d", edge_n);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_bringup();
    test_press();
    test_glitch();
    test_calib_loss();
    test_btn_held();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
